// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter that serialises read/write requests onto one
// single-port synchronous RAM, issuing a one-cycle strobe and returning an ack.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_ack0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_ram_read,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic                  i_ram_done,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_busy,
  output logic                  o_grant,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a master raises req (level) with stable we/addr/wdata; the
  // request is captured at grant and completed by a one-cycle ack, after which
  // the master must drop req or present its next request.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  win1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win1     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          // A lone requester wins; on contention the pointer decides.
          win1    = i_req1 & (~i_req0 | ptr_q);
          grant_d = win1;
          ptr_d   = ~win1;
          we_d    = win1 ? i_we1    : i_we0;
          addr_d  = win1 ? i_addr1  : i_addr0;
          wdata_d = win1 ? i_wdata1 : i_wdata0;
          read_d  = ~we_d;
          write_d = we_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i_ram_done) begin
          if (!we_q) begin
            if (grant_q) rdata1_d = i_ram_data;
            else         rdata0_d = i_ram_data;
          end
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign o_ack0        = ack0_q;
  assign o_ack1        = ack1_q;
  assign o_rdata0      = rdata0_q;
  assign o_rdata1      = rdata1_q;
  assign o_ram_read    = read_q;
  assign o_ram_write   = write_q;
  assign o_ram_address = addr_q;
  assign o_ram_data    = wdata_q;
  assign o_busy        = busy_q;
  assign o_grant       = grant_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM, driver tasks, and a
// scoreboard queue of {master, rdata} popped by a monitor on every ack.
module tb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = DW + 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_req0, i_we0, i_req1, i_we1;
  logic [AW-1:0] i_addr0, i_addr1;
  logic [DW-1:0] i_wdata0, i_wdata1;
  logic          o_ack0, o_ack1;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic          o_ram_read, o_ram_write;
  logic [AW-1:0] o_ram_address;
  logic [DW-1:0] o_ram_data;
  logic          i_ram_done = 1'b0;
  logic [DW-1:0] i_ram_data = '0;
  logic          o_busy, o_grant;
  logic [1:0]    o_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] ref_rdata [2];
  logic [DW-1:0] ram_mem [2**AW];
  logic          mem_init_done = 1'b0;

  always #5 i_clk = ~i_clk;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .o_ack0(o_ack0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_ack1(o_ack1), .o_rdata1(o_rdata1),
    .o_ram_read(o_ram_read), .o_ram_write(o_ram_write),
    .o_ram_address(o_ram_address), .o_ram_data(o_ram_data),
    .i_ram_done(i_ram_done), .i_ram_data(i_ram_data),
    .o_busy(o_busy), .o_grant(o_grant), .o_dbg_state(o_dbg_state)
  );

  // RAM model: registered access, done one cycle after the strobe, data held.
  always @(posedge i_clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2**AW; i++) ram_mem[i] <= DW'(i * 17);
      mem_init_done <= 1'b1;
    end
    i_ram_done <= o_ram_read | o_ram_write;
    if (o_ram_write) ram_mem[o_ram_address] <= o_ram_data;
    if (o_ram_read)  i_ram_data <= ram_mem[o_ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (m == 0) begin
      i_req0 = req; i_we0 = we; i_addr0 = addr; i_wdata0 = wdata;
    end else begin
      i_req1 = req; i_we1 = we; i_addr1 = addr; i_wdata1 = wdata;
    end
  endtask

  task automatic push_exp(input int m, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    logic mb;
    mb = (m != 0);
    if (we) ref_mem[addr] = wdata;
    else    ref_rdata[m] = ref_mem[addr];
    exp_q.push_back({mb, ref_rdata[m]});
  endtask

  // One transaction from an idle arbiter; corrupt_at/drop_at name the cycle
  // (1 = ISSUE) at which the master scrambles its fields or drops req.
  task automatic do_txn(input int m, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int corrupt_at, input int drop_at);
    int n, nstrobe;
    logic got, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    n = 0; nstrobe = 0; got = 1'b0; s_we = 1'b0; s_addr = '0; s_data = '0;
    push_exp(m, we, addr, wdata);
    set_master(m, 1'b1, we, addr, wdata);
    while (!got && n < 20) begin
      tick();
      n++;
      if (o_ram_read || o_ram_write) begin
        nstrobe++;
        s_we = o_ram_write; s_addr = o_ram_address; s_data = o_ram_data;
      end
      if (n == 1) begin
        check("grant_idx", o_grant, m);
        check("busy_in_issue", o_busy, 1);
      end
      got = (m == 0) ? o_ack0 : o_ack1;
      if (n == corrupt_at) set_master(m, 1'b1, we, 4'd9, 8'hFF);
      if (n == drop_at)    set_master(m, 1'b0, we, addr, wdata);
    end
    check("ack_latency", n, 3);
    check("strobe_count", nstrobe, 1);
    check("strobe_kind", s_we, we);
    check("ram_addr", s_addr, addr);
    if (we) check("ram_wdata", s_data, wdata);
    set_master(m, 1'b0, 1'b0, '0, '0);
    tick();
    check("back_idle_busy", o_busy, 0);
    check("back_idle_state", o_dbg_state, 0);
  endtask

  initial begin
    int n;
    logic [W-1:0] e;
    logic mb;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = DW'(i * 17);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    i_rst_n = 1'b0;
    set_master(0, 1'b1, 1'b0, 4'd1, 8'h00);
    set_master(1, 1'b1, 1'b0, 4'd2, 8'h00);

    fork
      forever begin
        @(negedge i_clk);
        check("two_acks", {31'd0, o_ack0 & o_ack1}, 0);
        check("two_strobes", {31'd0, o_ram_read & o_ram_write}, 0);
        if (o_ack0 || o_ack1) begin
          mb = o_ack1;
          if (exp_q.size() == 0) begin
            check("ack_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_master", mb, e[W-1]);
            check("ack_rdata", mb ? o_rdata1 : o_rdata0, e[DW-1:0]);
          end
        end
      end
    join_none

    // Reset held with both requests pending.
    repeat (3) begin
      tick();
      check("rst_ctl", {o_ack0, o_ack1, o_ram_read, o_ram_write, o_busy, o_grant, o_dbg_state}, 0);
      check("rst_data", {o_rdata0, o_rdata1, o_ram_address, o_ram_data}, 0);
    end
    i_rst_n = 1'b1;
    push_exp(0, 1'b0, 4'd1, 8'h00);
    push_exp(1, 1'b0, 4'd2, 8'h00);
    n = 0;
    while (!o_ack0 && n < 20) begin tick(); n++; end
    check("first_grant_ack0_cycle", n, 3);
    set_master(0, 1'b0, 1'b0, '0, '0);
    while (!o_ack1 && n < 40) begin tick(); n++; end
    check("second_grant_ack1_cycle", n, 7);
    set_master(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Contention: both masters hold reads for 16 cycles.
    set_master(0, 1'b1, 1'b0, 4'd1, 8'h00);
    set_master(1, 1'b1, 1'b0, 4'd2, 8'h00);
    push_exp(0, 1'b0, 4'd1, 8'h00);
    push_exp(1, 1'b0, 4'd2, 8'h00);
    push_exp(0, 1'b0, 4'd1, 8'h00);
    push_exp(1, 1'b0, 4'd2, 8'h00);
    repeat (16) tick();
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    check("contention_all_acked", exp_q.size(), 0);
    check("contention_rdata0", o_rdata0, 8'h11);
    check("contention_rdata1", o_rdata1, 8'h22);
    tick();
    tick();

    // Write then read on master 0.
    do_txn(0, 1'b1, 4'd5, 8'hA7, 0, 0);
    do_txn(0, 1'b0, 4'd5, 8'h00, 0, 0);
    check("rdata0_after_read", o_rdata0, 8'hA7);

    // Field isolation on master 1, then read both addresses back.
    do_txn(1, 1'b1, 4'd3, 8'h5C, 1, 0);
    do_txn(0, 1'b0, 4'd9, 8'h00, 0, 0);
    do_txn(1, 1'b0, 4'd3, 8'h00, 0, 0);
    check("rdata1_isolated", o_rdata1, 8'h5C);

    // Early drop during WAIT, and a write that must leave rdata1 alone.
    do_txn(0, 1'b0, 4'd5, 8'h00, 0, 2);
    do_txn(1, 1'b1, 4'd7, 8'h3C, 0, 0);
    check("rdata1_kept_on_write", o_rdata1, 8'h5C);

    // Reset in WAIT abandons the transaction.
    set_master(0, 1'b1, 1'b0, 4'd1, 8'h00);
    tick();
    tick();
    check("midrst_in_wait", o_dbg_state, 2);
    i_rst_n = 1'b0;
    set_master(0, 1'b0, 1'b0, '0, '0);
    tick();
    check("midrst_busy", o_busy, 0);
    check("midrst_acks", {o_ack0, o_ack1}, 0);
    check("midrst_state", o_dbg_state, 0);
    check("midrst_rdata", {o_rdata0, o_rdata1}, 0);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    i_rst_n = 1'b1;
    tick();
    check("midrst_idle_after_done", o_dbg_state, 0);
    do_txn(0, 1'b0, 4'd9, 8'h00, 0, 0);
    do_txn(1, 1'b1, 4'd2, 8'h00, 0, 0);
    do_txn(1, 1'b0, 4'd7, 8'h00, 0, 0);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM (one-cycle registered access, `o_done` pulse, `o_data` hold).
- Accepts read/write requests from two independent masters and serializes them onto the single RAM port.
- Drives the RAM strobes for exactly one cycle per access and waits for `done`.
- Returns a one-cycle acknowledge, with read data, to the granted master.
- Sits between the RAM instance and its two clients, e.g. a core load/store path and a DMA/debug port.

## Interface
- `DATA_WIDTH`, 8, word width; must match the RAM.
- `ADDR_WIDTH`, 4, address width; must match the RAM.
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_req0` / `i_req1` in 1: request from master 0 / 1; level, held until ack.
- `i_we0` / `i_we1` in 1: 1 = write, 0 = read; valid while req high.
- `i_addr0` / `i_addr1` in ADDR_WIDTH: access address.
- `i_wdata0` / `i_wdata1` in DATA_WIDTH: write data.
- `o_ack0` / `o_ack1` out 1: one-cycle completion pulse.
- `o_rdata0` / `o_rdata1` out DATA_WIDTH: read data; valid while matching ack is high, held afterwards.
- `o_ram_read` out 1: to RAM `i_read`.
- `o_ram_write` out 1: to RAM `i_write`.
- `o_ram_address` out ADDR_WIDTH: to RAM `i_address`.
- `o_ram_data` out DATA_WIDTH: to RAM `i_data`.
- `i_ram_done` in 1: from RAM `o_done`.
- `i_ram_data` in DATA_WIDTH: from RAM `o_data`.
- `o_busy` out 1: high in any state other than IDLE.
- `o_grant` out 1: index of the master owning the current or last transaction.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, grant one master, latch its we/addr/wdata into internal registers, update `o_grant`, and go to ISSUE.
  - If no req is high, stay in IDLE.
- Arbitration is round-robin with a 1-bit priority pointer.
  - If both reqs are high, the pointer's master wins.
  - After every grant, the pointer is set to the non-granted master.
  - A single requester always wins, regardless of the pointer.
- ISSUE: exactly one of `o_ram_read`/`o_ram_write` is high for exactly one cycle, per the latched `we`; both are never high together. `o_ram_address`/`o_ram_data` come from the latched registers. Go to WAIT.
- WAIT: strobes low. When `i_ram_done` = 1:
  - For a read, capture `i_ram_data` into the granted master's `o_rdata`.
  - Go to RESP.
- RESP:
  - The granted master's `o_ack` is high for this one cycle only; the other ack stays 0.
  - Go to IDLE.
  - A write leaves `o_rdata` unchanged.
- Latched request fields are immune to master-side changes after grant.
- If req is dropped before ack, the transaction still completes and still acks.
- A master must deassert req or present its next request in the cycle after its ack. Req still high in IDLE is a new request.
- `o_ram_address`/`o_ram_data` hold their last values outside ISSUE; only the strobes qualify them.
- Reset (`i_rst_n` = 0 at a rising edge), from any state:
  - State goes to IDLE and the pointer to master 0.
  - All outputs go to 0: `o_ram_read`, `o_ram_write`, `o_ram_address`, `o_ram_data`, `o_ack*`, `o_rdata*`, `o_busy`, `o_grant`.
  - An in-flight transaction is abandoned with no ack.
  - A `i_ram_done` that arrives after reset is ignored in IDLE.

## Timing
- All outputs are registered.
- Cycle 0: req high, FSM in IDLE.
- Cycle 1: ISSUE, strobe high; `o_busy` goes high.
- Cycle 2: WAIT; `i_ram_done` seen, since the RAM responds one cycle after the strobe.
- Cycle 3: RESP, ack high, read data valid.
- Cycle 4: IDLE; the next grant is possible here.
- Request-to-ack latency is 3 cycles. Back-to-back throughput is one access per 4 cycles.
- WAIT lasts as long as `i_ram_done` is low. There is no timeout; with the specified RAM it lasts exactly 1 cycle.
- Contended, with both reqs held continuously: grants alternate 0,1,0,1…, and each master gets an ack every 8 cycles.

## Test plan
- Reset: hold `i_rst_n` = 0 for 3 cycles with both reqs high. Required:
  - All outputs stay 0 and no strobe is issued.
  - The first grant after release goes to master 0, with its ack at cycle 3.
- Single write then read on master 0: write addr 5, data 0xA7, ack at cycle 3; then read addr 5. Required: `o_ram_read` pulses one cycle, `o_ack0` goes high, and `o_rdata0` = 0xA7.
- Contention: both masters hold reads on addr 1 (0x11) and addr 2 (0x22) for 16 cycles. Required:
  - The ack order is 0,1,0,1.
  - `o_rdata0` = 0x11 and `o_rdata1` = 0x22.
  - No cycle has both acks high, and no cycle has read and write strobes high together.
- Field isolation: master 1 writes addr 3, data 0x5C, then changes addr/wdata to 9/0xFF in the cycle after grant. Required: the RAM sees addr 3, data 0x5C, and a later read of addr 9 returns its old contents.
- Early drop: master 0 deasserts req in WAIT. Required: `o_ack0` still pulses in RESP and the FSM returns to IDLE.
- Mid-op reset: assert `i_rst_n` = 0 during WAIT. Required:
  - No ack is issued and `o_busy` = 0 next cycle.
  - The following request completes normally with 3-cycle latency.
